// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants and types for the keypad entry sequencer.
//   KEY_NONE/KEY_BACK/KEY_ENTER/KEY_CLEAR : special driver codes
//   kp_state_e                            : press/release debounce states
//   bcd_t                                 : one BCD digit
package keypad_pkg;

    localparam int KEY_W = 5;

    localparam logic [KEY_W-1:0] KEY_NONE  = 5'd16;
    localparam logic [KEY_W-1:0] KEY_BACK  = 5'd13;
    localparam logic [KEY_W-1:0] KEY_ENTER = 5'd14;
    localparam logic [KEY_W-1:0] KEY_CLEAR = 5'd15;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        S_UP     = 2'd0,
        S_DEB_DN = 2'd1,
        S_HELD   = 2'd2,
        S_DEB_UP = 2'd3
    } kp_state_e;

    function automatic logic is_digit(input logic [KEY_W-1:0] c);
        return c <= 5'd9;
    endfunction

endpackage

// File: rtl/keypad_press_filter.sv
// keypad_press_filter: stretches the per-column key level over one scan
// period, debounces press and release, and produces one accept strobe per
// press.
//   gclk, grst_n    : clock, async active-low reset
//   key_code_i      : driver code (16 = none)
//   key_idle_i      : 1 = no key on current column
//   acc_o           : combinational strobe, a real key is accepted this clock
//   acc_code_o      : code accepted with acc_o
//   key_event_o     : registered one-clock pulse per accepted key
//   key_last_o      : registered code of the last accepted key
module keypad_press_filter
    import keypad_pkg::*;
#(
    parameter int SCAN_COLS  = 4,
    parameter int DEB_CYCLES = 3
) (
    input  logic             gclk,
    input  logic             grst_n,
    input  logic [KEY_W-1:0] key_code_i,
    input  logic             key_idle_i,
    output logic             acc_o,
    output logic [KEY_W-1:0] acc_code_o,
    output logic             key_event_o,
    output logic [KEY_W-1:0] key_last_o
);

    localparam int CW = (SCAN_COLS > 1) ? $clog2(SCAN_COLS) : 1;
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] STR_RELOAD = CW'(SCAN_COLS - 1);
    localparam logic [DW-1:0] DEB_MAX    = DW'(DEB_CYCLES);
    localparam logic [DW-1:0] DEB_ONE    = DW'(1);

    logic [CW-1:0]    str_q, str_d;
    logic [DW-1:0]    deb_q, deb_d;
    kp_state_e        st_q, st_d;
    logic             evt_q, evt_d;
    logic [KEY_W-1:0] last_q, last_d;
    logic             down;
    logic             accept;

    // The driver only asserts key_idle=0 on the pressed key's column, so the
    // level is held for a full scan period to look continuous.
    assign down = !key_idle_i || (str_q != '0);

    always_comb begin
        str_d = str_q;
        if (!key_idle_i)      str_d = STR_RELOAD;
        else if (str_q != '0) str_d = str_q - 1'b1;
    end

    always_comb begin
        st_d   = st_q;
        deb_d  = deb_q;
        accept = 1'b0;
        case (st_q)
            S_UP: begin
                if (down) begin
                    st_d  = S_DEB_DN;
                    deb_d = DEB_ONE;
                end
            end
            S_DEB_DN: begin
                if (!down) begin
                    st_d  = S_UP;
                    deb_d = '0;
                end else if (deb_q == DEB_MAX) begin
                    st_d   = S_HELD;
                    deb_d  = '0;
                    accept = 1'b1;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            S_HELD: begin
                // The first up clock counts toward the release window, so a
                // one-clock window returns straight to S_UP.
                if (!down) begin
                    if (DEB_CYCLES == 1) begin
                        st_d  = S_UP;
                        deb_d = '0;
                    end else begin
                        st_d  = S_DEB_UP;
                        deb_d = DEB_ONE;
                    end
                end
            end
            S_DEB_UP: begin
                if (down) begin
                    st_d  = S_HELD;
                    deb_d = '0;
                end else if (deb_q == DEB_MAX - 1'b1) begin
                    st_d  = S_UP;
                    deb_d = '0;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            default: begin
                st_d  = S_UP;
                deb_d = '0;
            end
        endcase
    end

    // An accept with no code on the bus still consumes the press.
    assign acc_o      = accept && (key_code_i != KEY_NONE);
    assign acc_code_o = key_code_i;

    always_comb begin
        evt_d  = acc_o;
        last_d = acc_o ? key_code_i : last_q;
    end

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            str_q  <= '0;
            deb_q  <= '0;
            st_q   <= S_UP;
            evt_q  <= 1'b0;
            last_q <= '0;
        end else begin
            str_q  <= str_d;
            deb_q  <= deb_d;
            st_q   <= st_d;
            evt_q  <= evt_d;
            last_q <= last_d;
        end
    end

    assign key_event_o = evt_q;
    assign key_last_o  = last_q;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: turns debounced key events into a multi-digit BCD
// entry and hands committed entries downstream over valid/ready.
// Optional feature macro: KEYPAD_BACKSPACE_EN (code 13 deletes newest digit).
//   gclk, grst_n  : clock, async active-low reset
//   key_code_i    : driver code 0-15 key, 16 none
//   key_idle_i    : 1 = no key on current column
//   out_ready_i   : downstream accepts out_value_o
//   out_value_o   : committed BCD entry, digit 0 in [3:0]
//   out_count_o   : digits in out_value_o
//   out_valid_o   : out_value_o/out_count_o valid
//   disp_bcd_o    : live entry buffer
//   disp_count_o  : digits in buffer
//   overflow_o    : sticky, a digit was dropped on a full buffer
//   key_event_o   : one-clock pulse per accepted key
//   key_last_o    : last accepted key code
module keypad_entry_ctrl
    import keypad_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int SCAN_COLS  = 4,
    parameter int DEB_CYCLES = 3
) (
    input  logic              gclk,
    input  logic              grst_n,
    input  logic [KEY_W-1:0]  key_code_i,
    input  logic              key_idle_i,
    input  logic              out_ready_i,
    output logic [4*NDIG-1:0] out_value_o,
    output logic [3:0]        out_count_o,
    output logic              out_valid_o,
    output logic [4*NDIG-1:0] disp_bcd_o,
    output logic [3:0]        disp_count_o,
    output logic              overflow_o,
    output logic              key_event_o,
    output logic [KEY_W-1:0]  key_last_o
);

    localparam logic [3:0] NDIG_C = 4'(NDIG);

    logic             acc;
    logic [KEY_W-1:0] acc_code;
    bcd_t             dig;

    logic [4*NDIG-1:0] disp_q, disp_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [4*NDIG-1:0] oval_q, oval_d;
    logic [3:0]        ocnt_q, ocnt_d;
    logic              ovld_q, ovld_d;

    keypad_press_filter #(
        .SCAN_COLS  (SCAN_COLS),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_filter (
        .gclk        (gclk),
        .grst_n      (grst_n),
        .key_code_i  (key_code_i),
        .key_idle_i  (key_idle_i),
        .acc_o       (acc),
        .acc_code_o  (acc_code),
        .key_event_o (key_event_o),
        .key_last_o  (key_last_o)
    );

    assign dig = acc_code[3:0];

    always_comb begin
        disp_d = disp_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        oval_d = oval_q;
        ocnt_d = ocnt_q;
        ovld_d = ovld_q;

        if (ovld_q && out_ready_i) ovld_d = 1'b0;

        if (acc) begin
            if (is_digit(acc_code)) begin
                if (cnt_q == NDIG_C) begin
                    ovf_d = 1'b1;
                end else begin
                    // Shift on the flat vector so NDIG=1 needs no special case.
                    disp_d = (disp_q << 4) | {{(4*NDIG-4){1'b0}}, dig};
                    cnt_d  = cnt_q + 1'b1;
                end
            end else begin
                case (acc_code)
                    KEY_ENTER: begin
                        // Checks the registered valid, so an enter landing on
                        // the handshake clock is dropped.
                        if (cnt_q != '0 && !ovld_q) begin
                            oval_d = disp_q;
                            ocnt_d = cnt_q;
                            ovld_d = 1'b1;
                            disp_d = '0;
                            cnt_d  = '0;
                            ovf_d  = 1'b0;
                        end
                    end
                    KEY_CLEAR: begin
                        disp_d = '0;
                        cnt_d  = '0;
                        ovf_d  = 1'b0;
                    end
`ifdef KEYPAD_BACKSPACE_EN
                    KEY_BACK: begin
                        if (cnt_q != '0) begin
                            disp_d = disp_q >> 4;
                            cnt_d  = cnt_q - 1'b1;
                            ovf_d  = 1'b0;
                        end
                    end
`else
                    KEY_BACK: begin
                        disp_d = disp_q;
                    end
`endif
                    default: begin
                        disp_d = disp_q;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            disp_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            oval_q <= '0;
            ocnt_q <= '0;
            ovld_q <= 1'b0;
        end else begin
            disp_q <= disp_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            oval_q <= oval_d;
            ocnt_q <= ocnt_d;
            ovld_q <= ovld_d;
        end
    end

    assign disp_bcd_o   = disp_q;
    assign disp_count_o = cnt_q;
    assign overflow_o   = ovf_q;
    assign out_value_o  = oval_q;
    assign out_count_o  = ocnt_q;
    assign out_valid_o  = ovld_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
module tb_keypad_entry_ctrl;

    logic        gclk = 1'b0;
    logic        grst_n = 1'b0;
    logic [4:0]  key_code = 5'd16;
    logic        key_idle = 1'b1;
    logic        out_ready = 1'b0;

    logic [15:0] out_value, disp_bcd;
    logic [3:0]  out_count, disp_count;
    logic        out_valid, overflow, key_event;
    logic [4:0]  key_last;

    logic [15:0] b_out_value, b_disp_bcd;
    logic [3:0]  b_out_count, b_disp_count;
    logic        b_out_valid, b_overflow, b_key_event;
    logic [4:0]  b_key_last;

    int total = 0;
    int bad = 0;
    int ev_cnt = 0;
    int ev5_cnt = 0;
    int e0, e5;

    always #5 gclk = ~gclk;

    keypad_entry_ctrl #(.NDIG(4), .SCAN_COLS(4), .DEB_CYCLES(3)) dut (
        .gclk(gclk), .grst_n(grst_n), .key_code_i(key_code), .key_idle_i(key_idle),
        .out_ready_i(out_ready), .out_value_o(out_value), .out_count_o(out_count),
        .out_valid_o(out_valid), .disp_bcd_o(disp_bcd), .disp_count_o(disp_count),
        .overflow_o(overflow), .key_event_o(key_event), .key_last_o(key_last)
    );

    keypad_entry_ctrl #(.NDIG(4), .SCAN_COLS(4), .DEB_CYCLES(5)) dut5 (
        .gclk(gclk), .grst_n(grst_n), .key_code_i(key_code), .key_idle_i(key_idle),
        .out_ready_i(out_ready), .out_value_o(b_out_value), .out_count_o(b_out_count),
        .out_valid_o(b_out_valid), .disp_bcd_o(b_disp_bcd), .disp_count_o(b_disp_count),
        .overflow_o(b_overflow), .key_event_o(b_key_event), .key_last_o(b_key_last)
    );

    always @(posedge gclk) begin
        if (key_event)   ev_cnt  <= ev_cnt + 1;
        if (b_key_event) ev5_cnt <= ev5_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [4:0] c);
        @(negedge gclk);
        key_code = c;
        key_idle = 1'b0;
        repeat (8) @(negedge gclk);
        key_idle = 1'b1;
        key_code = 5'd16;
        repeat (12) @(negedge gclk);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge gclk);
        chk("rst_disp", {16'd0, disp_bcd}, 32'h0);
        chk("rst_cnt", {28'd0, disp_count}, 32'h0);
        chk("rst_valid", {31'd0, out_valid}, 32'h0);
        chk("rst_event", {31'd0, key_event}, 32'h0);
        chk("rst_last", {27'd0, key_last}, 32'h0);
        grst_n = 1'b1;
        repeat (3) @(negedge gclk);

        // long hold of key 5, exact accept latency
        e0 = ev_cnt;
        key_code = 5'd5;
        key_idle = 1'b0;
        @(posedge gclk);
        repeat (2) @(posedge gclk);
        #1 chk("lat_early", {31'd0, key_event}, 32'h0);
        @(posedge gclk);
        #1 chk("lat_event", {31'd0, key_event}, 32'h1);
        chk("lat_last", {27'd0, key_last}, 32'd5);
        chk("lat_disp", {16'd0, disp_bcd}, 32'h0005);
        repeat (16) @(negedge gclk);
        key_idle = 1'b1;
        key_code = 5'd16;
        repeat (12) @(negedge gclk);
        chk("hold_one_event", ev_cnt - e0, 1);
        chk("hold_cnt", {28'd0, disp_count}, 32'd1);

        // one-clock glitch: stretched down window of 4 clocks
        press(5'd15);
        e0 = ev_cnt;
        e5 = ev5_cnt;
        key_code = 5'd3;
        key_idle = 1'b0;
        @(negedge gclk);
        key_idle = 1'b1;
        repeat (6) @(negedge gclk);
        key_code = 5'd16;
        repeat (10) @(negedge gclk);
        chk("glitch_deb3", ev_cnt - e0, 1);
        chk("glitch_deb5", ev5_cnt - e5, 0);
        chk("glitch_disp", {16'd0, disp_bcd}, 32'h0003);

        // overflow and commit
        press(5'd15);
        press(5'd1); press(5'd2); press(5'd3); press(5'd4); press(5'd5);
        chk("ovf_disp", {16'd0, disp_bcd}, 32'h1234);
        chk("ovf_flag", {31'd0, overflow}, 32'h1);
        press(5'd14);
        chk("commit_val", {16'd0, out_value}, 32'h1234);
        chk("commit_cnt", {28'd0, out_count}, 32'd4);
        chk("commit_vld", {31'd0, out_valid}, 32'h1);
        chk("commit_disp", {16'd0, disp_bcd}, 32'h0);
        chk("commit_ovf", {31'd0, overflow}, 32'h0);

        // enter blocked while valid pending
        press(5'd7);
        press(5'd14);
        chk("blk_disp", {16'd0, disp_bcd}, 32'h0007);
        chk("blk_val", {16'd0, out_value}, 32'h1234);
        chk("blk_vld", {31'd0, out_valid}, 32'h1);
        out_ready = 1'b1;
        @(posedge gclk);
        #1 chk("hs_drop", {31'd0, out_valid}, 32'h0);
        chk("hs_hold_val", {16'd0, out_value}, 32'h1234);
        @(negedge gclk);
        out_ready = 1'b0;
        press(5'd14);
        chk("commit2_val", {16'd0, out_value}, 32'h0007);
        chk("commit2_cnt", {28'd0, out_count}, 32'd1);
        chk("commit2_vld", {31'd0, out_valid}, 32'h1);

        // enter on empty buffer does nothing
        out_ready = 1'b1;
        repeat (2) @(negedge gclk);
        out_ready = 1'b0;
        press(5'd14);
        chk("empty_enter", {31'd0, out_valid}, 32'h0);

        // backspace
        press(5'd9); press(5'd8); press(5'd13);
`ifdef KEYPAD_BACKSPACE_EN
        chk("bs_disp", {16'd0, disp_bcd}, 32'h0009);
        chk("bs_cnt", {28'd0, disp_count}, 32'd1);
`else
        chk("bs_disp", {16'd0, disp_bcd}, 32'h0098);
        chk("bs_cnt", {28'd0, disp_count}, 32'd2);
`endif
        chk("bs_last", {27'd0, key_last}, 32'd13);

        // ignored key still pulses; none-code at accept gives no event
        e0 = ev_cnt;
        press(5'd10);
        chk("ign_event", ev_cnt - e0, 1);
        chk("ign_last", {27'd0, key_last}, 32'd10);
        e0 = ev_cnt;
        press(5'd16);
        chk("none_event", ev_cnt - e0, 0);

        // reset mid-operation
        press(5'd15);
        press(5'd1); press(5'd14);
        press(5'd4); press(5'd2);
        chk("pre_rst_vld", {31'd0, out_valid}, 32'h1);
        chk("pre_rst_cnt", {28'd0, disp_count}, 32'd2);
        #2 grst_n = 1'b0;
        #1;
        chk("mrst_vld", {31'd0, out_valid}, 32'h0);
        chk("mrst_val", {16'd0, out_value}, 32'h0);
        chk("mrst_disp", {16'd0, disp_bcd}, 32'h0);
        chk("mrst_cnt", {28'd0, disp_count}, 32'd0);
        chk("mrst_last", {27'd0, key_last}, 32'd0);
        repeat (3) @(negedge gclk);
        grst_n = 1'b1;
        e0 = ev_cnt;
        repeat (12) @(negedge gclk);
        chk("mrst_no_event", ev_cnt - e0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
